// File: rtl/kill_search_scheduler.sv
// kill_search_scheduler: iterative-deepening driver for a kill-search engine with cycle budget and cancel.
module kill_search_scheduler #(
  parameter int BUDGET  = 100000,
  parameter int DEPTH_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_cancel,
  input  logic [DEPTH_W-1:0] i_max_depth,
  input  logic [224:0][1:0]  i_board,
  output logic               o_eng_start,
  output logic [DEPTH_W-1:0] o_eng_depth,
  output logic [224:0][1:0]  o_eng_board,
  output logic               o_eng_abort,
  input  logic               i_eng_sha,
  input  logic               i_eng_finish,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_kill,
  output logic [DEPTH_W-1:0] o_kill_depth,
  output logic               o_timeout
);
  localparam int CW = $clog2(BUDGET + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ABORT, DONE} state_t;
  state_t state, state_nxt;
  logic [DEPTH_W-1:0] depth, limit, even_md;
  logic [DEPTH_W:0]   depth_sum;
  logic [CW-1:0]      cnt;
  logic               last, expired;
  assign even_md   = {i_max_depth[DEPTH_W-1:1], 1'b0};
  assign depth_sum = {1'b0, depth} + (DEPTH_W+1)'(2);
  assign last      = depth_sum > {1'b0, limit};
  // Counter parks at the budget mark, so a finish that wins the race at expiry still leaves the budget spent.
  assign expired   = cnt == CW'(BUDGET - 1);
  always_ff @(posedge i_clk)
    if (i_rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !i_start ? IDLE : (even_md < DEPTH_W'(2)) ? DONE : LAUNCH;
      LAUNCH:  state_nxt = i_cancel ? ABORT : WAIT;
      WAIT:    state_nxt = i_cancel ? ABORT :
                           i_eng_finish ? ((i_eng_sha || last) ? DONE : LAUNCH) :
                           expired ? ABORT : WAIT;
      ABORT:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_eng_board  <= '0;
      limit        <= '0;
      depth        <= '0;
      cnt          <= '0;
      o_kill       <= 1'b0;
      o_kill_depth <= '0;
      o_timeout    <= 1'b0;
    end else begin
      if (state == IDLE && i_start) begin
        o_eng_board  <= i_board;
        limit        <= even_md;
        depth        <= DEPTH_W'(2);
        cnt          <= '0;
        o_kill       <= 1'b0;
        o_kill_depth <= '0;
        o_timeout    <= 1'b0;
      end
      if ((state == LAUNCH || state == WAIT) && !expired) cnt <= cnt + 1'b1;
      if (state == WAIT && !i_cancel && i_eng_finish) begin
        if (i_eng_sha) begin
          o_kill       <= 1'b1;
          o_kill_depth <= depth;
        end else if (!last) depth <= depth_sum[DEPTH_W-1:0];
      end
      if (state == ABORT) begin
        o_kill       <= 1'b0;
        o_kill_depth <= '0;
        o_timeout    <= 1'b1;
      end
    end
  assign o_eng_start = state == LAUNCH;
  assign o_eng_abort = state == ABORT;
  assign o_done      = state == DONE;
  assign o_busy      = state != IDLE;
  assign o_eng_depth = depth;
endmodule

// File: tb/tb_kill_search_scheduler.sv
// tb_kill_search_scheduler: vector table of searches against a behavioural engine, plus cancel/busy/reset sequences.
module tb_kill_search_scheduler;
  logic clk = 0, rst = 1, start = 0, cancel = 0, eng_sha = 0, eng_finish = 0;
  logic [4:0] max_depth = 0;
  logic [224:0][1:0] board = '0, board_a;
  logic eng_start, eng_abort, busy, done, kill, timeout;
  logic [4:0] eng_depth, kill_depth;
  logic [224:0][1:0] eng_board;
  int errors = 0, checks = 0;
  kill_search_scheduler #(.BUDGET(20), .DEPTH_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cancel(cancel), .i_max_depth(max_depth),
    .i_board(board), .o_eng_start(eng_start), .o_eng_depth(eng_depth), .o_eng_board(eng_board),
    .o_eng_abort(eng_abort), .i_eng_sha(eng_sha), .i_eng_finish(eng_finish), .o_busy(busy),
    .o_done(done), .o_kill(kill), .o_kill_depth(kill_depth), .o_timeout(timeout)
  );
  always #5 clk = ~clk;
  typedef struct {int md; int kill_at; int delay; int starts; int kill; int kd; int to; int aborts;} vec_t;
  vec_t vt[9];
  task automatic chk(input string n, input logic [449:0] a, input logic [449:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic rand_board();
    for (int i = 0; i < 225; i++) board[i] = 2'($urandom_range(0, 2));
  endtask
  task automatic run(input vec_t v);
    int starts = 0, aborts = 0, cd = -1, exp_d = 2, cur = 0, guard = 0;
    rand_board();
    board_a = board;
    @(negedge clk);
    start = 1;
    max_depth = 5'(v.md);
    @(negedge clk);
    start = 0;
    rand_board();
    while (!done && guard < 100) begin
      eng_finish = 0;
      eng_sha = 0;
      if (eng_start) begin
        chk("eng_depth", 450'(eng_depth), 450'(exp_d));
        exp_d += 2;
        starts++;
        cd = v.delay;
        cur = int'(eng_depth);
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          eng_finish = 1;
          eng_sha = (cur == v.kill_at);
          cd = -1;
        end
      end
      if (eng_abort) aborts++;
      @(negedge clk);
      guard++;
    end
    eng_finish = 0;
    eng_sha = 0;
    chk("done_seen", 450'(done), 450'(1));
    chk("starts", 450'(starts), 450'(v.starts));
    chk("aborts", 450'(aborts), 450'(v.aborts));
    chk("kill", 450'(kill), 450'(v.kill));
    chk("kill_depth", 450'(kill_depth), 450'(v.kd));
    chk("timeout", 450'(timeout), 450'(v.to));
    chk("eng_board", 450'(eng_board), 450'(board_a));
    @(negedge clk);
    chk("idle_after_done", 450'({busy, done}), 450'(0));
    chk("kill_held", 450'(kill), 450'(v.kill));
  endtask
  initial begin
    vt[0] = '{6, 4, 2, 2, 1, 4, 0, 0};
    vt[1] = '{5, 0, 1, 2, 0, 0, 0, 0};
    vt[2] = '{1, 0, 1, 0, 0, 0, 0, 0};
    vt[3] = '{0, 0, 1, 0, 0, 0, 0, 0};
    vt[4] = '{2, 2, 3, 1, 1, 2, 0, 0};
    vt[5] = '{31, 0, 0, 1, 0, 0, 1, 1};
    vt[6] = '{31, 2, 19, 1, 1, 2, 0, 0};
    vt[7] = '{4, 2, 20, 1, 0, 0, 1, 1};
    vt[8] = '{8, 8, 1, 4, 1, 8, 0, 0};
    rand_board();
    start = 1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", 450'({eng_start, eng_depth, eng_abort, busy, done, kill, kill_depth, timeout}), 450'(0));
    chk("reset_board", 450'(eng_board), 450'(0));
    start = 0;
    rst = 0;
    @(negedge clk);
    chk("idle_after_reset", 450'(busy), 450'(0));
    for (int i = 0; i < 9; i++) run(vt[i]);
    rand_board();
    board_a = board;
    start = 1;
    max_depth = 6;
    @(negedge clk);
    chk("launch_pulse", 450'(eng_start), 450'(1));
    rand_board();
    max_depth = 2;
    @(negedge clk);
    start = 0;
    chk("busy_in_wait", 450'({busy, eng_start}), 450'(2));
    chk("board_stable", 450'(eng_board), 450'(board_a));
    chk("depth_stable", 450'(eng_depth), 450'(2));
    cancel = 1;
    eng_finish = 1;
    eng_sha = 1;
    @(negedge clk);
    cancel = 0;
    eng_finish = 0;
    eng_sha = 0;
    chk("cancel_abort", 450'({eng_abort, done}), 450'(2));
    @(negedge clk);
    chk("cancel_done", 450'({done, eng_abort, kill, kill_depth, timeout}), 450'({1'b1, 1'b0, 1'b0, 5'd0, 1'b1}));
    @(negedge clk);
    chk("cancel_idle", 450'(busy), 450'(0));
    start = 1;
    max_depth = 6;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("pre_reset_wait", 450'(busy), 450'(1));
    rst = 1;
    @(negedge clk);
    chk("rst_wait_outputs", 450'({eng_start, eng_depth, eng_abort, busy, done, kill, kill_depth, timeout}), 450'(0));
    chk("rst_wait_board", 450'(eng_board), 450'(0));
    rst = 0;
    @(negedge clk);
    chk("rst_no_done", 450'({done, eng_abort, busy}), 450'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
